// File: rtl/rgmii_link_ctrl_pkg.sv
// Shared constants and types for the RGMII link-speed controller.
package rgmii_pkg;

  // Link speed encoding, identical to the PHYSR speed field
  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;
  localparam logic [1:0] SPD_RSVD = 2'b11;

  // PHYSR (reg 0x11) bit positions
  localparam int PHYSR_SPD_HI = 15;
  localparam int PHYSR_SPD_LO = 14;
  localparam int PHYSR_LINK   = 10;

  // Clause-22 read frame fields
  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;

  // Frame field lengths in MDC periods (sum = 64)
  localparam int PRE_BITS  = 32;
  localparam int CMD_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;

  typedef enum logic [2:0] {
    MS_IDLE,
    MS_PRE,
    MS_CMD,
    MS_TA,
    MS_DATA,
    MS_UPDATE
  } mdio_state_t;

  typedef struct packed {
    logic [1:0] spd;
    logic       lnk;
  } physr_t;

  // 10M and 100M use the SDR receive path
  function automatic logic is_sdr(input logic [1:0] spd);
    return spd != SPD_1000;
  endfunction

endpackage

// File: rtl/rgmii_link_ctrl_if.sv
// MDIO pads, poll request and link status seen by the RGMII PHY interface.
interface rgmii_link_ctrl_if;
  logic       poll_req;
  logic       mdio_i;
  logic       mdc;
  logic       mdio_o;
  logic       mdio_t;
  logic [1:0] link_speed;
  logic       mii_select;
  logic       link_up;
  logic       dp_reset;
  logic       busy;
  logic       rd_err;

  // controller side
  modport master (
    input  poll_req, mdio_i,
    output mdc, mdio_o, mdio_t, link_speed, mii_select, link_up,
           dp_reset, busy, rd_err
  );

  // pad / MAC side
  modport slave (
    output poll_req, mdio_i,
    input  mdc, mdio_o, mdio_t, link_speed, mii_select, link_up,
           dp_reset, busy, rd_err
  );
endinterface

// File: rtl/rgmii_link_ctrl_mdio_rd_master.sv
// Clause-22 MDIO read master: MDC generator and PRE/CMD/TA/DATA shifter.
// One 'start' runs a 64-period read frame; 'done' pulses in UPDATE with rdata valid.
module mdio_rd_master
  import rgmii_pkg::*;
#(
  parameter int         MDC_HALF   = 25,
  parameter logic [4:0] PHY_ADDR   = 5'd1,
  parameter logic [4:0] STATUS_REG = 5'h11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mdio_i,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata
);

  localparam int HW = $clog2(MDC_HALF + 1);
  localparam logic [13:0] CMD_WORD = {MDIO_ST, MDIO_OP_RD, PHY_ADDR, STATUS_REG};

  mdio_state_t   state;
  logic [HW-1:0] half_cnt;
  logic [4:0]    bit_cnt;   // MDC period index within the current field
  logic [13:0]   cmd_sr;
  logic          half_end;

  assign half_end = (half_cnt == HW'(MDC_HALF - 1));

  // Frame sequencer. mdc toggles at half_end; the rising toggle samples
  // mdio_i, the falling toggle closes a period and drives the next bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MS_IDLE;
      mdc      <= 1'b0;
      mdio_o   <= 1'b1;
      mdio_t   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      half_cnt <= '0;
      bit_cnt  <= '0;
      cmd_sr   <= '0;
      rdata    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MS_IDLE: begin
          if (start) begin
            // first preamble bit goes out with the start edge
            state    <= MS_PRE;
            busy     <= 1'b1;
            mdio_t   <= 1'b0;
            mdio_o   <= 1'b1;
            half_cnt <= '0;
            bit_cnt  <= '0;
            cmd_sr   <= CMD_WORD;
          end
        end
        MS_UPDATE: begin
          state <= MS_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          if (!half_end) begin
            half_cnt <= half_cnt + HW'(1);
          end else begin
            half_cnt <= '0;
            mdc      <= ~mdc;
            if (!mdc) begin
              if (state == MS_DATA) rdata <= {rdata[14:0], mdio_i};
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              case (state)
                MS_PRE: begin
                  if (bit_cnt == 5'(PRE_BITS - 1)) begin
                    state   <= MS_CMD;
                    bit_cnt <= '0;
                    mdio_o  <= cmd_sr[13];
                    cmd_sr  <= {cmd_sr[12:0], 1'b0};
                  end
                end
                MS_CMD: begin
                  if (bit_cnt == 5'(CMD_BITS - 1)) begin
                    // release the line for turnaround and data
                    state   <= MS_TA;
                    bit_cnt <= '0;
                    mdio_t  <= 1'b1;
                    mdio_o  <= 1'b1;
                  end else begin
                    mdio_o <= cmd_sr[13];
                    cmd_sr <= {cmd_sr[12:0], 1'b0};
                  end
                end
                MS_TA: begin
                  if (bit_cnt == 5'(TA_BITS - 1)) begin
                    state   <= MS_DATA;
                    bit_cnt <= '0;
                  end
                end
                MS_DATA: begin
                  if (bit_cnt == 5'(DATA_BITS - 1)) begin
                    state <= MS_UPDATE;
                    done  <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/rgmii_link_ctrl.sv
// Link-speed controller: polls PHYSR over MDIO, drives link_speed/mii_select
// and holds the MAC datapath in reset across speed changes.
module rgmii_link_ctrl
  import rgmii_pkg::*;
#(
  parameter int         MDC_HALF    = 25,
  parameter logic [4:0] PHY_ADDR    = 5'd1,
  parameter logic [4:0] STATUS_REG  = 5'h11,
  parameter int         POLL_CYCLES = 12_500_000,
  parameter int         HOLD_CYCLES = 16
) (
  input  logic               clk_125,
  input  logic               reset,
  rgmii_link_ctrl_if.master  ctl
);

  localparam int TW = $clog2(POLL_CYCLES);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [TW-1:0] poll_tmr;
  logic          tmr_exp;
  logic          pending;
  logic          start;
  logic          mbusy;
  logic          done;
  logic [15:0]   rdata;
  physr_t        sr;
  logic [CW-1:0] hold_cnt;
  logic [1:0]    link_speed;
  logic          mii_select;
  logic          link_up;
  logic          dp_reset;
  logic          rd_err;
  logic          unused_physr;

  assign tmr_exp = (poll_tmr == TW'(POLL_CYCLES - 1));
  // timer expiry, a fresh request and a pending request all collapse into one start
  assign start   = !mbusy && (ctl.poll_req || pending || tmr_exp);

  assign sr.spd       = rdata[PHYSR_SPD_HI:PHYSR_SPD_LO];
  assign sr.lnk       = rdata[PHYSR_LINK];
  assign unused_physr = ^{rdata[13:11], rdata[9:0]};

  mdio_rd_master #(
    .MDC_HALF   (MDC_HALF),
    .PHY_ADDR   (PHY_ADDR),
    .STATUS_REG (STATUS_REG)
  ) u_mdio (
    .clk    (clk_125),
    .rst    (reset),
    .start  (start),
    .mdio_i (ctl.mdio_i),
    .mdc    (ctl.mdc),
    .mdio_o (ctl.mdio_o),
    .mdio_t (ctl.mdio_t),
    .busy   (mbusy),
    .done   (done),
    .rdata  (rdata)
  );

  // Poll timer restarts on every frame start; requests during a frame merge into one pending bit
  always_ff @(posedge clk_125 or posedge reset) begin
    if (reset) begin
      poll_tmr <= '0;
      pending  <= 1'b0;
    end else begin
      if (start || tmr_exp) poll_tmr <= '0;
      else                  poll_tmr <= poll_tmr + TW'(1);
      if (start)                       pending <= 1'b0;
      else if (mbusy && ctl.poll_req)  pending <= 1'b1;
    end
  end

  // PHYSR decode on frame completion and datapath reset hold
  always_ff @(posedge clk_125 or posedge reset) begin
    if (reset) begin
      link_speed <= SPD_1000;
      mii_select <= 1'b0;
      link_up    <= 1'b0;
      rd_err     <= 1'b0;
      dp_reset   <= 1'b1;
      hold_cnt   <= CW'(HOLD_CYCLES - 1);
    end else begin
      if (hold_cnt != '0) hold_cnt <= hold_cnt - CW'(1);
      else                dp_reset <= 1'b0;
      if (done) begin
        if (sr.spd == SPD_RSVD) begin
          rd_err <= 1'b1;
        end else begin
          rd_err  <= 1'b0;
          link_up <= sr.lnk;
          if (sr.lnk && sr.spd != link_speed) begin
            // a change inside an active hold restarts the count
            link_speed <= sr.spd;
            mii_select <= is_sdr(sr.spd);
            dp_reset   <= 1'b1;
            hold_cnt   <= CW'(HOLD_CYCLES - 1);
          end
        end
      end
    end
  end

  assign ctl.busy       = mbusy;
  assign ctl.link_speed = link_speed;
  assign ctl.mii_select = mii_select;
  assign ctl.link_up    = link_up;
  assign ctl.dp_reset   = dp_reset;
  assign ctl.rd_err     = rd_err;

endmodule

// File: tb/tb_rgmii_link_ctrl.sv
// Directed bench for rgmii_link_ctrl with a PHYSR-returning MDIO PHY model.
module tb_rgmii_link_ctrl;

  localparam int POLL      = 8000;
  localparam int HOLD      = 16;
  localparam int HALF      = 25;
  localparam int FRAME_CYC = 64 * 2 * HALF + 1;   // 64 MDC periods plus UPDATE

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          fc = 0;
  logic        mdc_q = 1'b0;
  logic [15:0] phy_data = 16'h0000;

  rgmii_link_ctrl_if ifc ();

  rgmii_link_ctrl #(
    .MDC_HALF    (HALF),
    .PHY_ADDR    (5'd1),
    .STATUS_REG  (5'h11),
    .POLL_CYCLES (POLL),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_125 (clk),
    .reset   (rst),
    .ctl     (ifc.master)
  );

  always #4 clk = ~clk;

  // free-running cycle count for interval measurements
  always @(posedge clk) cyc <= cyc + 1;

  // PHY model: counts MDC falling edges; periods 48..63 carry phy_data MSB first
  always @(negedge clk) begin
    mdc_q <= ifc.mdc;
    if (rst || !ifc.busy)          fc <= 0;
    else if (mdc_q && !ifc.mdc)    fc <= fc + 1;
    ifc.mdio_i <= (fc >= 48 && fc <= 63) ? phy_data[63 - fc] : 1'b1;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic pulse_poll();
    ifc.poll_req = 1'b1;
    @(negedge clk);
    ifc.poll_req = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int lim, output int n);
    n = 0;
    while (ifc.busy !== lvl && n < lim) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ifc.busy !== lvl) begin
      bad++;
      $display("FAIL busy_wait: busy=%b after %0d cycles, want %b", ifc.busy, n, lvl);
    end
  endtask

  task automatic test_reset();
    logic [9:0] got;
    int n;
    rst = 1'b1;
    ifc.poll_req = 1'b0;
    repeat (3) @(negedge clk);
    got = {ifc.link_speed, ifc.mii_select, ifc.link_up, ifc.dp_reset,
           ifc.busy, ifc.rd_err, ifc.mdc, ifc.mdio_o, ifc.mdio_t};
    total++;
    if (got !== 10'b1000100011) begin
      bad++;
      $display("FAIL reset_values: got %b want %b", got, 10'b1000100011);
    end
    rst = 1'b0;
    n = 0;
    while (ifc.dp_reset === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != HOLD) begin
      bad++;
      $display("FAIL reset_hold: dp_reset dropped on edge %0d, want %0d", n, HOLD);
    end
  endtask

  task automatic test_first_poll();
    int n;
    logic dp_seen;
    phy_data = 16'hA400;
    pulse_poll();
    wait_busy(1'b0, 4000, n);
    total++;
    if (n != FRAME_CYC) begin
      bad++;
      $display("FAIL busy_length: got %0d want %0d", n, FRAME_CYC);
    end
    dp_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dp_seen = dp_seen | ifc.dp_reset;
      @(negedge clk);
    end
    total++;
    if ({ifc.link_up, ifc.link_speed, ifc.mii_select, ifc.rd_err} !== 5'b1_10_0_0) begin
      bad++;
      $display("FAIL poll_1000: got up/spd/mii/err=%b want %b",
               {ifc.link_up, ifc.link_speed, ifc.mii_select, ifc.rd_err}, 5'b11000);
    end
    total++;
    if (dp_seen !== 1'b0) begin
      bad++;
      $display("FAIL no_change_dp: dp_reset=%b want 0", dp_seen);
    end
  endtask

  task automatic test_speed_change();
    int n;
    phy_data = 16'h6400;
    pulse_poll();
    wait_busy(1'b0, 4000, n);
    total++;
    if ({ifc.link_up, ifc.link_speed, ifc.mii_select} !== 4'b1_01_1) begin
      bad++;
      $display("FAIL speed_100: got up/spd/mii=%b want %b",
               {ifc.link_up, ifc.link_speed, ifc.mii_select}, 4'b1011);
    end
    n = 0;
    while (ifc.dp_reset === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != HOLD) begin
      bad++;
      $display("FAIL change_hold: dp_reset high %0d cycles, want %0d", n, HOLD);
    end
  endtask

  task automatic test_frame_capture();
    logic [63:0] o_bits;
    logic [63:0] t_bits;
    logic [45:0] exp_o;
    logic [63:0] exp_t;
    logic pm;
    int k, n, last, pmin, pmax;
    exp_o = {32'hFFFF_FFFF, 14'b01_10_00001_10001};
    exp_t = {46'd0, 18'h3FFFF};
    phy_data = 16'h6400;
    total++;
    if ({ifc.mdc, ifc.mdio_t} !== 2'b01) begin
      bad++;
      $display("FAIL idle_pads: mdc/mdio_t=%b want 01", {ifc.mdc, ifc.mdio_t});
    end
    o_bits = '0;
    t_bits = '0;
    last = 0;
    pmin = 1000000;
    pmax = 0;
    pulse_poll();
    for (int p = 0; p < 64; p++) begin
      k = 0;
      do begin
        pm = ifc.mdc;
        @(negedge clk);
        k++;
      end while (!(pm === 1'b0 && ifc.mdc === 1'b1) && k < 200);
      o_bits[63 - p] = ifc.mdio_o;
      t_bits[63 - p] = ifc.mdio_t;
      if (p > 0) begin
        if (cyc - last < pmin) pmin = cyc - last;
        if (cyc - last > pmax) pmax = cyc - last;
      end
      last = cyc;
    end
    total++;
    if (o_bits[63:18] !== exp_o) begin
      bad++;
      $display("FAIL frame_mdio_o: got %b want %b", o_bits[63:18], exp_o);
    end
    total++;
    if (t_bits !== exp_t) begin
      bad++;
      $display("FAIL frame_mdio_t: got %h want %h", t_bits, exp_t);
    end
    total++;
    if (pmin != 2 * HALF || pmax != 2 * HALF) begin
      bad++;
      $display("FAIL mdc_period: min %0d max %0d want %0d", pmin, pmax, 2 * HALF);
    end
    wait_busy(1'b0, 4000, n);
  endtask

  task automatic test_pending();
    int n, t0;
    phy_data = 16'h6400;
    pulse_poll();
    repeat (100) @(negedge clk);
    pulse_poll();
    repeat (1000) @(negedge clk);
    pulse_poll();
    repeat (1000) @(negedge clk);
    pulse_poll();
    wait_busy(1'b0, 4000, n);
    wait_busy(1'b1, 50, n);
    total++;
    if (n != 1) begin
      bad++;
      $display("FAIL pending_gap: idle %0d cycles before extra frame, want 1", n);
    end
    t0 = cyc;
    wait_busy(1'b0, 4000, n);
    total++;
    if (n != FRAME_CYC) begin
      bad++;
      $display("FAIL extra_frame_len: got %0d want %0d", n, FRAME_CYC);
    end
    wait_busy(1'b1, POLL + 100, n);
    total++;
    if (cyc - t0 != POLL) begin
      bad++;
      $display("FAIL timer_restart: next auto poll after %0d cycles, want %0d", cyc - t0, POLL);
    end
    wait_busy(1'b0, 4000, n);
  endtask

  task automatic test_rsvd_speed();
    int n;
    phy_data = 16'hE400;
    pulse_poll();
    wait_busy(1'b0, 4000, n);
    total++;
    if ({ifc.rd_err, ifc.link_up, ifc.link_speed, ifc.mii_select, ifc.dp_reset} !== 6'b1_1_01_1_0) begin
      bad++;
      $display("FAIL rsvd_speed: got err/up/spd/mii/dp=%b want %b",
               {ifc.rd_err, ifc.link_up, ifc.link_speed, ifc.mii_select, ifc.dp_reset}, 6'b110110);
    end
    phy_data = 16'h0000;
    pulse_poll();
    wait_busy(1'b0, 4000, n);
    total++;
    if ({ifc.rd_err, ifc.link_up, ifc.link_speed, ifc.mii_select, ifc.dp_reset} !== 6'b0_0_01_1_0) begin
      bad++;
      $display("FAIL link_down: got err/up/spd/mii/dp=%b want %b",
               {ifc.rd_err, ifc.link_up, ifc.link_speed, ifc.mii_select, ifc.dp_reset}, 6'b000110);
    end
  endtask

  task automatic test_reset_abort();
    int n, k;
    phy_data = 16'h2400;
    pulse_poll();
    k = 0;
    while (fc < 56 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({ifc.mdio_t, ifc.mdc, ifc.busy, ifc.link_speed, ifc.dp_reset, ifc.link_up} !== 7'b1_0_0_10_1_0) begin
      bad++;
      $display("FAIL abort_state: got t/mdc/busy/spd/dp/up=%b want %b",
               {ifc.mdio_t, ifc.mdc, ifc.busy, ifc.link_speed, ifc.dp_reset, ifc.link_up}, 7'b1001010);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (ifc.dp_reset === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    pulse_poll();
    wait_busy(1'b0, 4000, n);
    total++;
    if (n != FRAME_CYC) begin
      bad++;
      $display("FAIL clean_frame_len: got %0d want %0d", n, FRAME_CYC);
    end
    total++;
    if ({ifc.link_up, ifc.link_speed, ifc.mii_select, ifc.dp_reset} !== 5'b1_00_1_1) begin
      bad++;
      $display("FAIL speed_10: got up/spd/mii/dp=%b want %b",
               {ifc.link_up, ifc.link_speed, ifc.mii_select, ifc.dp_reset}, 5'b10011);
    end
  endtask

  initial begin
    ifc.poll_req = 1'b0;
    test_reset();
    test_first_poll();
    test_speed_change();
    test_frame_capture();
    test_pending();
    test_rsvd_speed();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
